// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if: sample stream, result stream and coefficient port of fir_mac_sequencer.
interface fir_mac_sequencer_if #(parameter int DW = 18);
   logic          i_valid;
   logic          i_ready;
   logic [DW-1:0] i_in;
   logic          o_valid;
   logic          o_ready;
   logic [DW-1:0] o_out;
   logic          cfg_we;
   logic [2:0]    cfg_addr;
   logic [DW-1:0] cfg_data;
   logic          cfg_err;
   logic          busy;
   modport master (
      output i_valid, i_in, o_ready, cfg_we, cfg_addr, cfg_data,
      input  i_ready, o_valid, o_out, cfg_err, busy
   );
   modport slave (
      input  i_valid, i_in, o_ready, cfg_we, cfg_addr, cfg_data,
      output i_ready, o_valid, o_out, cfg_err, busy
   );
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: 16-tap symmetric FIR sharing one multiplier over 8 MAC cycles per sample.
module fir_mac_sequencer #(
   parameter int DW   = 18,
   parameter int NTAP = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clk_ena,
   fir_mac_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;
   localparam int C_INIT [8] = '{88, 0, -97, -197, -294, -380, -447, -490};
   state_t        r_state;
   logic [DW-1:0] r_dl [NTAP];
   logic [DW-1:0] r_coef [NTAP/2];
   logic [DW-1:0] r_sample;
   logic [DW-1:0] r_acc;
   logic [DW-1:0] r_out;
   logic [3:0]    r_wr_ptr;
   logic [2:0]    r_k;
   logic          r_valid;
   logic          r_err;
   logic          r_busy;
   logic [3:0]    w_ia;
   logic [3:0]    w_ib;
   logic [DW-1:0] w_sum;
   logic [DW-1:0] w_acc_next;
   // r_wr_ptr already points past the newest sample, so newest-15+k lands on r_wr_ptr+k
   assign w_ia       = r_wr_ptr - 4'd1 - {1'b0, r_k};
   assign w_ib       = r_wr_ptr + {1'b0, r_k};
   assign w_sum      = r_dl[w_ia] + r_dl[w_ib];
   assign w_acc_next = r_acc + DW'(w_sum * r_coef[r_k]);
   assign bus.i_ready = clk_ena && r_state == IDLE;
   assign bus.o_valid = r_valid;
   assign bus.o_out   = r_out;
   assign bus.cfg_err = r_err;
   assign bus.busy    = r_busy;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_wr_ptr <= '0;
         r_k      <= '0;
         r_sample <= '0;
         r_acc    <= '0;
         r_out    <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_busy   <= 1'b0;
         for (int j = 0; j < NTAP; j++) r_dl[j] <= '0;
         for (int j = 0; j < NTAP/2; j++) r_coef[j] <= DW'(C_INIT[j]);
      end else if (clk_ena) begin
         r_err <= 1'b0;
         if (bus.cfg_we) begin
            if (r_state == IDLE || r_state == DONE) r_coef[bus.cfg_addr] <= bus.cfg_data;
            else r_err <= 1'b1;
         end
         case (r_state)
            IDLE: if (bus.i_valid) begin
               r_sample <= bus.i_in;
               r_busy   <= 1'b1;
               r_state  <= LOAD;
            end
            LOAD: begin
               r_dl[r_wr_ptr] <= r_sample;
               r_wr_ptr       <= r_wr_ptr + 4'd1;
               r_acc          <= '0;
               r_k            <= '0;
               r_state        <= MAC;
            end
            MAC: begin
               r_acc <= w_acc_next;
               r_k   <= r_k + 3'd1;
               if (r_k == 3'd7) begin
                  r_out   <= w_acc_next;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= DONE;
               end
            end
            DONE: if (bus.o_ready) begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed vectors and hand sequences for fir_mac_sequencer.
module tb_fir_mac_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clk_ena = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   fir_mac_sequencer_if #(.DW(18)) bus ();
   fir_mac_sequencer #(.DW(18), .NTAP(16)) dut (.clk(clk), .reset(reset), .clk_ena(clk_ena), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [17:0] x;
      logic [17:0] y;
   } vec_t;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_o_valid", bus.o_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_o_out", bus.o_out, 0);
      chk("rst_cfg_err", bus.cfg_err, 0);
      reset = 1'b0;
   endtask
   task automatic send(input logic [17:0] x, input int stall, output logic [17:0] y, output int lat);
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_in = x;
      for (int n = 0; n < 40 && !bus.i_ready; n++) @(negedge clk);
      @(negedge clk);
      bus.i_valid = 1'b0;
      lat = 1;
      while (!bus.o_valid && lat < 60) begin
         if (lat == stall) clk_ena = 1'b0;
         if (lat == stall + 3) clk_ena = 1'b1;
         @(negedge clk);
         lat++;
      end
      y = bus.o_out;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
   initial begin
      int exp_imp [17] = '{88, 0, 262047, 261947, 261850, 261764, 261697, 261654,
                           261654, 261697, 261764, 261850, 261947, 262047, 0, 88, 0};
      vec_t imp [17];
      logic [17:0] y;
      int lat;
      int acc_c [$];
      int ov_c [$];
      logic pv;
      int seen;
      bus.i_valid = 1'b0;
      bus.i_in = '0;
      bus.o_ready = 1'b1;
      bus.cfg_we = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_data = '0;
      for (int i = 0; i < 17; i++) begin
         imp[i].x = (i == 0) ? 18'd1 : 18'd0;
         imp[i].y = 18'(exp_imp[i]);
      end
      do_reset();
      chk("rst_i_ready", bus.i_ready, 1);
      for (int i = 0; i < 17; i++) begin
         send(imp[i].x, 0, y, lat);
         chk($sformatf("imp_out%0d", i), y, imp[i].y);
         chk($sformatf("imp_lat%0d", i), lat, 10);
      end
      @(negedge clk);
      bus.i_in = '0;
      bus.i_valid = 1'b1;
      pv = 1'b0;
      for (int c = 0; c < 34; c++) begin
         if (bus.i_ready) acc_c.push_back(c);
         if (bus.o_valid && !pv) ov_c.push_back(c);
         pv = bus.o_valid;
         if (c == 33) bus.i_valid = 1'b0;
         @(negedge clk);
      end
      chk("cont_accepts", acc_c.size(), 4);
      chk("cont_results", ov_c.size(), 3);
      for (int i = 0; i < 3 && i + 1 < acc_c.size() && i < ov_c.size(); i++) begin
         chk($sformatf("cont_spacing%0d", i), acc_c[i+1] - acc_c[i], 11);
         chk($sformatf("cont_lat%0d", i), ov_c[i] - acc_c[i], 10);
      end
      bus.o_ready = 1'b0;
      send(18'd2, 0, y, lat);
      chk("hold_first", y, 176);
      chk("hold_lat", lat, 10);
      for (int c = 0; c < 5; c++) begin
         chk("hold_out", bus.o_out, 176);
         chk("hold_valid", bus.o_valid, 1);
         chk("hold_i_ready", bus.i_ready, 0);
         @(negedge clk);
      end
      chk("hold_valid6", bus.o_valid, 1);
      bus.o_ready = 1'b1;
      @(negedge clk);
      chk("hold_consumed", bus.o_valid, 0);
      chk("hold_idle_ready", bus.i_ready, 1);
      do_reset();
      bus.i_valid = 1'b1;
      bus.i_in = 18'd1;
      @(negedge clk);
      bus.i_valid = 1'b0;
      chk("load_i_ready", bus.i_ready, 0);
      @(negedge clk);
      @(negedge clk);
      chk("mac_busy", bus.busy, 1);
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 3'd0;
      bus.cfg_data = 18'd5;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      chk("cfg_err_pulse", bus.cfg_err, 1);
      @(negedge clk);
      chk("cfg_err_clear", bus.cfg_err, 0);
      for (int n = 0; n < 40 && !bus.o_valid; n++) @(negedge clk);
      chk("cfg_drop_valid", bus.o_valid, 1);
      chk("cfg_drop_out", bus.o_out, 88);
      chk("done_busy", bus.busy, 0);
      @(negedge clk);
      bus.cfg_we = 1'b1;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      chk("cfg_idle_no_err", bus.cfg_err, 0);
      send(18'd1, 0, y, lat);
      chk("cfg_new_coef", y, 5);
      do_reset();
      send(18'd3, 0, y, lat);
      chk("ena_ref_out", y, 264);
      chk("ena_ref_lat", lat, 10);
      do_reset();
      send(18'd3, 4, y, lat);
      chk("ena_stall_out", y, 264);
      chk("ena_stall_lat", lat, 13);
      do_reset();
      bus.i_valid = 1'b1;
      bus.i_in = 18'd1;
      @(negedge clk);
      bus.i_valid = 1'b0;
      for (int n = 0; n < 5; n++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int n = 0; n < 12; n++) begin
         if (bus.o_valid || bus.busy) seen++;
         @(negedge clk);
      end
      chk("abort_no_result", seen, 0);
      send(18'd0, 0, y, lat);
      chk("abort_flush0", y, 0);
      send(18'd0, 0, y, lat);
      chk("abort_flush1", y, 0);
      send(18'd1, 0, y, lat);
      chk("abort_impulse", y, 88);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 The block SHALL have parameter DW, default 18, sample/coefficient/result width (only 18 is supported).
REQ-002 The block SHALL have parameter NTAP, default 16, number of symmetric taps (only 16 is supported; 8 unique coefficients).
REQ-003 The block SHALL have port clk, input, 1 bit, clock.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port clk_ena, input, 1 bit, global clock enable.
REQ-006 The block SHALL have port i_valid, input, 1 bit, input sample offered.
REQ-007 The block SHALL have port i_ready, output, 1 bit, sample accepted this cycle if i_valid is also high.
REQ-008 The block SHALL have port i_in, input, DW bits, input sample (two's complement).
REQ-009 The block SHALL have port o_valid, output, 1 bit, o_out holds a result.
REQ-010 The block SHALL have port o_ready, input, 1 bit, downstream consumes the result.
REQ-011 The block SHALL have port o_out, output, DW bits, filter result.
REQ-012 The block SHALL have port cfg_we, input, 1 bit, coefficient write strobe.
REQ-013 The block SHALL have port cfg_addr, input, 3 bits, coefficient index 0..7.
REQ-014 The block SHALL have port cfg_data, input, DW bits, coefficient value.
REQ-015 The block SHALL have port cfg_err, output, 1 bit, one-cycle pulse when a write is dropped.
REQ-016 The block SHALL have port busy, output, 1 bit, high in the LOAD and MAC states.

Function
REQ-017 The block SHALL implement FSM states IDLE, LOAD, MAC and DONE; every state, counter, register and handshake SHALL freeze while clk_ena=0.
REQ-018 The block SHALL drive i_ready = clk_ena AND (state==IDLE); IDLE SHALL go to LOAD on i_valid&&i_ready.
REQ-019 The block SHALL, in LOAD (1 cycle), write the accepted sample to a 16-entry circular delay line at wr_ptr, advance wr_ptr (15 wraps to 0), clear the accumulator and set k=0.
REQ-020 The block SHALL, in MAC (8 cycles, k=0..7), perform acc += ((x[n-k]+x[n-15+k]) mod 2^18 * c[k]) mod 2^18 in one multiplier, with all sums and products truncated to the low 18 bits (modular wrap, no saturation); x[n] is the newest sample.
REQ-021 The block SHALL, after k=7, load o_out with acc, set o_valid=1 and enter DONE.
REQ-022 The block SHALL hold o_valid and o_out stable in DONE until o_ready=1 with clk_ena=1, then clear o_valid and go to IDLE.
REQ-023 The block SHALL give an accept-to-o_valid latency of exactly 10 clk_ena cycles (LOAD 1 + MAC 8 + output register 1).
REQ-024 The block SHALL, on cfg_we=1 in IDLE or DONE, write cfg_data to c[cfg_addr] at the clock edge; the new value SHALL be used by the next LOAD.
REQ-025 The block SHALL drop a cfg_we=1 that arrives in LOAD or MAC (c unchanged) and pulse cfg_err high for 1 cycle.
REQ-026 The block SHALL treat i_valid as don't-care outside IDLE, with no sample lost or duplicated.

Reset
REQ-027 The block SHALL, while reset=1, asynchronously force state=IDLE, wr_ptr=0, all delay-line entries=0, acc=0, o_out=0, o_valid=0, cfg_err=0 and busy=0.
REQ-028 The block SHALL load coefficients c[0..7] at reset with 88, 0, -97, -197, -294, -380, -447, -490 (18-bit two's complement).
REQ-029 The block SHALL, on reset asserted mid-MAC or in DONE, abort the computation, discard the pending result and update no state after reset deasserts until the next sample is accepted.

Verification
REQ-030 The bench SHALL cover: reset, then samples 1,0,0,... (o_ready=1) -> outputs 88, 0, 262047, 261947, 261850, 261764, 261697, 261654, 261654, 261697, 261764, 261850, 261947, 262047, 0, 88, then 0.
REQ-031 The bench SHALL cover: i_valid held high continuously -> one accept per 11 cycles, i_ready low for 10 cycles after each accept, o_valid exactly 10 cycles after each accept.
REQ-032 The bench SHALL cover: o_ready=0 for 5 cycles in DONE -> o_out stable, i_ready=0 throughout, result consumed on the 6th cycle.
REQ-033 The bench SHALL cover: cfg_we with addr 0, data 5 during MAC -> cfg_err pulses, c[0] stays 88; the same write in IDLE, then an impulse -> first output 5.
REQ-034 The bench SHALL cover: clk_ena=0 for 3 cycles mid-MAC -> latency grows to 13 cycles, result identical to the clk_ena=1 result.
REQ-035 The bench SHALL cover: reset pulse at MAC k=4 -> o_valid stays 0, delay line cleared, next impulse gives 88.
